// File: rtl/twid_pkg.sv
// Shared twiddle types and the elaboration-time quarter-wave ROM word generator.
package twid_pkg;

    localparam int  TWID_W  = 32;
    localparam real TWID_PI = 3.14159265358979323846;

    // Wide enough for any DW up to TWID_W; users slice the low DW bits.
    typedef struct packed {
        logic signed [TWID_W-1:0] re;
        logic signed [TWID_W-1:0] im;
    } twid_t;

    // cos or sin of 2*pi*addr/fft_size scaled to 2^(dw-1)-1, rounded half away from zero.
    function automatic logic signed [TWID_W-1:0] twid_word(
        input int fft_size,
        input int dw,
        input int addr,
        input bit sel_sin
    );
        real ang;
        real amp;
        real v;
        ang = 2.0 * TWID_PI * real'(addr) / real'(fft_size);
        amp = real'((1 << (dw - 1)) - 1);
        v   = sel_sin ? ($sin(ang) * amp) : ($cos(ang) * amp);
        v   = (v >= 0.0) ? (v + 0.5) : (v - 0.5);
        return TWID_W'($rtoi(v));
    endfunction

endpackage

// File: rtl/twid_qrom.sv
// Registered dual-output quarter-wave ROM: cos/sin of 2*pi*addr/FFT_SIZE, addr in [0, FFT_SIZE/4).
module twid_qrom
    import twid_pkg::*;
#(
    parameter int  FFT_SIZE = 32,
    parameter int  DW       = 16,
    localparam int AW       = $clog2(FFT_SIZE) - 2,
    localparam int Q        = FFT_SIZE / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    output logic signed [DW-1:0] rd_cos,
    output logic signed [DW-1:0] rd_sin
);

    logic signed [DW-1:0] cos_rom [Q];
    logic signed [DW-1:0] sin_rom [Q];
    logic signed [DW-1:0] cos_d, cos_q;
    logic signed [DW-1:0] sin_d, sin_q;

    // Each entry packs (cos, sin) of one angle; only the low DW bits are stored.
    for (genvar a = 0; a < Q; a++) begin : g_rom
        localparam twid_t ENTRY = '{re: twid_word(FFT_SIZE, DW, a, 1'b0),
                                    im: twid_word(FFT_SIZE, DW, a, 1'b1)};
        assign cos_rom[a] = ENTRY.re[DW-1:0];
        assign sin_rom[a] = ENTRY.im[DW-1:0];
    end

    always_comb begin
        cos_d = cos_q;
        sin_d = sin_q;
        if (en) begin
            cos_d = cos_rom[addr];
            sin_d = sin_rom[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign rd_cos = cos_q;
    assign rd_sin = sin_q;

endmodule

// File: rtl/twid_rom_reader.sv
// Twiddle lookup W_N^k for k in [0, N/2): 3-stage stallable pipeline over a quarter-wave ROM.
// Define TWID_CONJ_EN to add in_conj, which returns conj(W) for the entry that carries it.
module twid_rom_reader
    import twid_pkg::*;
#(
    parameter int  FFT_SIZE = 32,
    parameter int  DW       = 16,
    localparam int W        = $clog2(FFT_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-2:0]         in_index,
`ifdef TWID_CONJ_EN
    input  logic                 in_conj,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);

    // valid/ready: a beat moves on a side when valid && ready at the rising edge; every
    // stage advances together only while the output register is empty or being drained.
    logic                 advance;
    logic                 take_conj;
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_quad_d, s1_quad_q;
    logic                 s1_conj_d, s1_conj_q;
    logic [W-3:0]         s1_addr_d, s1_addr_q;
    logic                 s2_valid_d, s2_valid_q;
    logic                 s2_quad_d, s2_quad_q;
    logic                 s2_conj_d, s2_conj_q;
    logic                 s3_valid_d, s3_valid_q;
    logic signed [DW-1:0] s3_re_d, s3_re_q;
    logic signed [DW-1:0] s3_im_d, s3_im_q;
    logic signed [DW-1:0] rom_cos, rom_sin, im_mag;

    assign advance  = !s3_valid_q || out_ready;
    assign in_ready = advance;

`ifdef TWID_CONJ_EN
    assign take_conj = in_conj;
`else
    assign take_conj = 1'b0;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_quad_d  = s1_quad_q;
        s1_addr_d  = s1_addr_q;
        s1_conj_d  = s1_conj_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_quad_d = in_index[W-2];
                s1_addr_d = in_index[W-3:0];
                s1_conj_d = take_conj;
            end
        end
    end

    twid_qrom #(
        .FFT_SIZE (FFT_SIZE),
        .DW       (DW)
    ) u_qrom (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (advance),
        .addr   (s1_addr_q),
        .rd_cos (rom_cos),
        .rd_sin (rom_sin)
    );

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_quad_d  = s2_quad_q;
        s2_conj_d  = s2_conj_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_quad_d  = s1_quad_q;
            s2_conj_d  = s1_conj_q;
        end
    end

    // Second quadrant: cos(x+pi/2) = -sin(x), sin(x+pi/2) = cos(x).
    assign im_mag = s2_quad_q ? rom_cos : rom_sin;

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_re_d    = s3_re_q;
        s3_im_d    = s3_im_q;
        if (advance) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_re_d = s2_quad_q ? -rom_sin : rom_cos;
                s3_im_d = s2_conj_q ? im_mag : -im_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_quad_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_conj_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_quad_q  <= 1'b0;
            s2_conj_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_re_q    <= '0;
            s3_im_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_quad_q  <= s1_quad_d;
            s1_addr_q  <= s1_addr_d;
            s1_conj_q  <= s1_conj_d;
            s2_valid_q <= s2_valid_d;
            s2_quad_q  <= s2_quad_d;
            s2_conj_q  <= s2_conj_d;
            s3_valid_q <= s3_valid_d;
            s3_re_q    <= s3_re_d;
            s3_im_q    <= s3_im_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_re    = s3_re_q;
    assign out_im    = s3_im_q;

endmodule

// File: tb/tb_twid_rom_reader.sv
// Directed bench for twid_rom_reader: N=32/DW=16 main instance plus N=8/64/1024 DW=12 sweeps.
module tb_twid_rom_reader;

    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               rst_n;
    logic               rst_sw_n;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_index;
`ifdef TWID_CONJ_EN
    logic               in_conj;
`endif
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    bit          sb_en    = 1'b0;
    bit          bp_stop  = 1'b0;
    bit          held_valid;
    logic [31:0] held_val;

    twid_rom_reader #(
        .FFT_SIZE (32),
        .DW       (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
`ifdef TWID_CONJ_EN
        .in_conj   (in_conj),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- golden model ----------------
    function automatic int round_haz(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    function automatic int gold_re(input int n, input int dw, input int k);
        return round_haz($cos(2.0 * PI * real'(k) / real'(n)) * real'((1 << (dw - 1)) - 1));
    endfunction

    function automatic int gold_im(input int n, input int dw, input int k);
        return round_haz(-$sin(2.0 * PI * real'(k) / real'(n)) * real'((1 << (dw - 1)) - 1));
    endfunction

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor (backpressure phase) ----------------
    initial begin
        held_valid = 1'b0;
        held_val   = '0;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (held_valid && !out_valid) check("bp_stall_drop", out_valid, 1);
                if (out_valid) begin
                    if (held_valid) check("bp_stall_hold", {out_re, out_im}, held_val);
                    if (out_ready) begin
                        if (exp_q.size() == 0) check("bp_extra_out", exp_q.size(), 1);
                        else check("bp_data", {out_re, out_im}, exp_q.pop_front());
                        held_valid = 1'b0;
                    end else begin
                        held_valid = 1'b1;
                        held_val   = {out_re, out_im};
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic test_b2b();
        logic [3:0] ks [4];
        int         er [4];
        int         ei [4];
        ks = '{4'd0, 4'd4, 4'd8, 4'd12};
        er = '{32767, 23170, 0, -23170};
        ei = '{0, -23170, -32767, -23170};
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_index = ks[c];
            @(negedge clk);
            if (c >= 3 && c < 7) begin
                check($sformatf("b2b_valid_c%0d", c), out_valid, 1);
                check($sformatf("b2b_re_c%0d", c), out_re, er[c-3]);
                check($sformatf("b2b_im_c%0d", c), out_im, ei[c-3]);
            end else begin
                check($sformatf("b2b_idle_c%0d", c), out_valid, 0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        int n_out = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0 || c == 3);
            in_index = (c == 0) ? 4'd1 : 4'd2;
            @(negedge clk);
            if (out_valid) n_out++;
            check($sformatf("bub_valid_c%0d", c), out_valid, (c == 3 || c == 6));
            if (c == 3) begin
                check("bub_re_k1", out_re, gold_re(32, 16, 1));
                check("bub_im_k1", out_im, gold_im(32, 16, 1));
            end
            if (c == 6) begin
                check("bub_re_k2", out_re, gold_re(32, 16, 2));
                check("bub_im_k2", out_im, gold_im(32, 16, 2));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bub_count", n_out, 2);
    endtask

`ifdef TWID_CONJ_EN
    task automatic test_conj();
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 2);
            in_index = 4'd4;
            in_conj  = (c == 0);
            @(negedge clk);
            check($sformatf("conj_valid_c%0d", c), out_valid, (c == 3 || c == 4));
            if (c == 3) begin
                check("conj_on_re", out_re, 23170);
                check("conj_on_im", out_im, 23170);
            end
            if (c == 4) begin
                check("conj_off_re", out_re, 23170);
                check("conj_off_im", out_im, -23170);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_conj  = 1'b0;
    endtask
`endif

    task automatic test_backpressure();
        for (int k = 0; k < 16; k++) begin
            logic [15:0] gr;
            logic [15:0] gi;
            gr = 16'(gold_re(32, 16, k));
            gi = 16'(gold_im(32, 16, k));
            exp_q.push_back({gr, gi});
        end
        bp_stop = 1'b0;
        sb_en   = 1'b1;
        fork
            begin : rdy_gen
                logic [31:0] pat;
                pat = 32'hB2E5_9C74;
                while (!bp_stop) begin
                    out_ready = pat[0];
                    pat = {pat[0], pat[31:1]};
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 16; k++) begin
            bit acc;
            acc      = 1'b0;
            in_valid = 1'b1;
            in_index = k[3:0];
            for (int b = 0; b < 64 && !acc; b++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) check($sformatf("bp_accept_k%0d", k), acc, 1);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("bp_drain", exp_q.size(), 0);
        bp_stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ks [3];
        int         n_ghost = 0;
        ks = '{4'd5, 4'd6, 4'd7};
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_index = ks[c];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        check("rsm_busy", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rsm_valid", out_valid, 0);
        check("rsm_re", out_re, 0);
        check("rsm_im", out_im, 0);
        check("rsm_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) n_ghost++;
        end
        check("rsm_no_ghost", n_ghost, 0);
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            in_index = 4'd15;
            @(negedge clk);
            check($sformatf("last_valid_c%0d", c), out_valid, (c == 3));
            if (c == 3) begin
                check("last_k15_re", out_re, -32137);
                check("last_k15_im", out_im, -6393);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // ---------------- size sweep instances (DW=12, out_ready tied high) ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SN = (g == 0) ? 8 : (g == 1) ? 64 : 1024;
        localparam int SW = $clog2(SN);
        logic               s_in_valid;
        logic               s_in_ready;
        logic [SW-2:0]      s_in_index;
        logic               s_out_valid;
        logic signed [11:0] s_re;
        logic signed [11:0] s_im;
        logic               done = 1'b0;

        twid_rom_reader #(
            .FFT_SIZE (SN),
            .DW       (12)
        ) u_sw (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .in_index  (s_in_index),
`ifdef TWID_CONJ_EN
            .in_conj   (1'b0),
`endif
            .out_valid (s_out_valid),
            .out_ready (1'b1),
            .out_re    (s_re),
            .out_im    (s_im)
        );

        initial begin
            s_in_valid = 1'b0;
            s_in_index = '0;
            wait (rst_sw_n);
            @(posedge clk); #1;
            for (int k = 0; k < SN / 2; k++) begin
                s_in_valid = 1'b1;
                s_in_index = k[SW-2:0];
                @(posedge clk); #1;
            end
            s_in_valid = 1'b0;
        end

        initial begin
            int got;
            got = 0;
            wait (rst_sw_n);
            for (int c = 0; c < SN / 2 + 20 && got < SN / 2; c++) begin
                @(negedge clk);
                if (s_out_valid) begin
                    check($sformatf("sw%0d_re_k%0d", SN, got), s_re, gold_re(SN, 12, got));
                    check($sformatf("sw%0d_im_k%0d", SN, got), s_im, gold_im(SN, 12, got));
                    if (got == SN / 4) begin
                        check($sformatf("sw%0d_quarter_re", SN), s_re, 0);
                        check($sformatf("sw%0d_quarter_im", SN), s_im, -2047);
                    end
                    got++;
                end
            end
            check($sformatf("sw%0d_count", SN), got, SN / 2);
            check($sformatf("sw%0d_ready", SN), s_in_ready, 1);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit all_done;
        in_valid  = 1'b0;
        in_index  = '0;
`ifdef TWID_CONJ_EN
        in_conj   = 1'b0;
`endif
        out_ready = 1'b1;
        rst_n     = 1'b0;
        rst_sw_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        test_b2b();
        test_bubbles();
`ifdef TWID_CONJ_EN
        test_conj();
`endif
        test_backpressure();
        test_reset_mid();

        all_done = 1'b0;
        for (int c = 0; c < 2000 && !all_done; c++) begin
            @(posedge clk);
            all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
        end
        check("sweep_all_done", all_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
